// File: rtl/rps_result_display.sv
// rps_result_display
//
// Consumer end of the game's 3-bit result code. It accepts one code over a
// valid/ready handshake, shows it on the three board LEDs for 2^HOLD_LOG2
// cycles, and then returns to the idle pattern. It also keeps saturating
// tallies of person wins, computer wins and ties, and drives the RGB LED to
// show which side is leading.
//
// Ports:
//   CLK, RST        clock; asynchronous active-high reset
//   result_valid    game offers a result code
//   result_ready    block can accept a code (high only in IDLE)
//   result          1 = PERSON_WINS, 2 = COMPUTER_WINS, 4 = TIE
//   clear_tallies   synchronous clear of the tallies and bad_code
//   led             {LED1, LED2, LED3}, active-high
//   LEDR_N          red, active-low: computer leading
//   LEDG_N          green, active-low: person leading
//   person_wins     person win tally
//   computer_wins   computer win tally
//   ties            tie tally
//   bad_code        sticky: a code outside {1,2,4} was accepted
//   dbg_state       current FSM state (0 = IDLE, 1 = SHOW)
//
// Handshake: a code transfers at a rising edge of CLK on which
// result_valid && result_ready are both high. result_ready depends only on
// the FSM state, never on result_valid. A transferred invalid code is
// consumed without leaving IDLE.

module rps_result_display #(
    parameter int HOLD_LOG2 = 25,
    parameter int BLINK_BIT = 21,
    parameter int SCORE_W   = 4
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               result_valid,
    output logic               result_ready,
    input  logic [2:0]         result,
    input  logic               clear_tallies,
    output logic [2:0]         led,
    output logic               LEDR_N,
    output logic               LEDG_N,
    output logic [SCORE_W-1:0] person_wins,
    output logic [SCORE_W-1:0] computer_wins,
    output logic [SCORE_W-1:0] ties,
    output logic               bad_code,
    output logic               dbg_state
);

    localparam logic [2:0] CODE_PERSON   = 3'd1;
    localparam logic [2:0] CODE_COMPUTER = 3'd2;
    localparam logic [2:0] CODE_TIE      = 3'd4;

    typedef enum logic {
        IDLE = 1'b0,
        SHOW = 1'b1
    } state_t;

    state_t               state;
    state_t               state_next;
    logic [2:0]           code;
    logic [HOLD_LOG2-1:0] hold_cnt;
    logic                 accept;
    logic                 code_ok;
    logic                 hold_done;

    assign accept    = result_valid && result_ready;
    assign code_ok   = (result == CODE_PERSON) || (result == CODE_COMPUTER) ||
                       (result == CODE_TIE);
    assign hold_done = (hold_cnt == {HOLD_LOG2{1'b1}});
    assign dbg_state = state;

    // State register
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and display outputs
    always_comb begin
        state_next   = state;
        result_ready = 1'b0;
        led          = 3'b111;
        case (state)
            IDLE: begin
                result_ready = 1'b1;
                led          = 3'b111;
                if (accept && code_ok) begin
                    state_next = SHOW;
                end
            end
            SHOW: begin
                result_ready = 1'b0;
                if (code == CODE_TIE) begin
                    led = 3'b001;
                end else if (hold_cnt[BLINK_BIT]) begin
                    led = 3'b000;
                end else begin
                    led = code;
                end
                if (hold_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Latched code and hold counter. The counter wraps to zero on the last
    // SHOW cycle, so it is already clear when IDLE is re-entered.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            code     <= 3'b000;
            hold_cnt <= '0;
        end else if (state == IDLE) begin
            if (accept && code_ok) begin
                code     <= result;
                hold_cnt <= '0;
            end
        end else begin
            hold_cnt <= hold_cnt + {{(HOLD_LOG2-1){1'b0}}, 1'b1};
        end
    end

    // Tallies and sticky bad-code flag; clear wins over a same-edge update.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            person_wins   <= '0;
            computer_wins <= '0;
            ties          <= '0;
            bad_code      <= 1'b0;
        end else if (clear_tallies) begin
            person_wins   <= '0;
            computer_wins <= '0;
            ties          <= '0;
            bad_code      <= 1'b0;
        end else if (accept) begin
            case (result)
                CODE_PERSON: begin
                    if (person_wins != {SCORE_W{1'b1}}) begin
                        person_wins <= person_wins + SCORE_W'(1);
                    end
                end
                CODE_COMPUTER: begin
                    if (computer_wins != {SCORE_W{1'b1}}) begin
                        computer_wins <= computer_wins + SCORE_W'(1);
                    end
                end
                CODE_TIE: begin
                    if (ties != {SCORE_W{1'b1}}) begin
                        ties <= ties + SCORE_W'(1);
                    end
                end
                default: begin
                    bad_code <= 1'b1;
                end
            endcase
        end
    end

    // Leader LEDs follow the tallies directly.
    assign LEDG_N = !(person_wins > computer_wins);
    assign LEDR_N = !(computer_wins > person_wins);

endmodule
